// File: rtl/vma_seq.sv
// ---------------------------------------------------------------------------
// vma_seq -- virtual memory address sequencer
//
// Arbitrates between the EBOX (single-word cycles) and the diagnostic port
// (bursts of 1..8 words). It owns the VMA register, starts memory cycles and
// waits for their completion. Page failures and address-break hits are
// trapped in a FAULT state until they are cleared.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   ebox_req/addr         EBOX one-word request and address [13:35]
//   ebox_write/fetch      EBOX cycle type (both 0 = data read)
//   diag_req/addr         diagnostic burst request and start address
//   diag_write            diagnostic cycle is a write
//   diag_count            burst length minus one
//   mem_ack, page_fail    memory cycle complete / page failed
//   brk_addr              address-break compare value
//   brk_rd/wr/fetch       address-break enables per cycle type
//   fault_clr             leaves FAULT
//   vma, vma_held         current address / address captured at a fault
//   mem_start             one-cycle pulse starting a memory cycle at vma
//   mem_write, grant_diag type and owner of the active cycle (valid while busy)
//   ebox_done, diag_done  one-cycle completion pulses
//   fault, fault_cause    FAULT state and cause (01 page fail, 10 break)
//   busy                  sequencer is not idle
// ---------------------------------------------------------------------------
module vma_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ebox_req,
    input  logic [22:0] ebox_addr,
    input  logic        ebox_write,
    input  logic        ebox_fetch,
    input  logic        diag_req,
    input  logic [22:0] diag_addr,
    input  logic        diag_write,
    input  logic [2:0]  diag_count,
    input  logic        mem_ack,
    input  logic        page_fail,
    input  logic [22:0] brk_addr,
    input  logic        brk_rd,
    input  logic        brk_wr,
    input  logic        brk_fetch,
    input  logic        fault_clr,
    output logic [22:0] vma,
    output logic [22:0] vma_held,
    output logic        mem_start,
    output logic        mem_write,
    output logic        grant_diag,
    output logic        ebox_done,
    output logic        diag_done,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_FAULT
    } state_t;

    state_t      state;
    logic [2:0]  count;
    logic        cur_fetch;
    logic        prio_diag;

    logic        any_req;
    logic        grant_ok;
    logic        pick_diag;
    logic        contested;
    logic        brk_en;
    logic        brk_hit;
    logic [22:0] vma_next;

    // Arbitration: diag wins when alone or when it holds the priority bit.
    // Grants are held off during the cycle a done pulse is out, so the
    // finishing requester has a cycle to drop its request.
    assign any_req   = ebox_req | diag_req;
    assign contested = ebox_req & diag_req;
    assign pick_diag = diag_req & (~ebox_req | prio_diag);
    assign grant_ok  = any_req & ~ebox_done & ~diag_done;

    // The break enable follows the latched cycle type; a fetch takes
    // precedence over write, and anything else counts as a read.
    always_comb begin
        brk_en = brk_rd;
        if (cur_fetch) begin
            brk_en = brk_fetch;
        end else if (mem_write) begin
            brk_en = brk_wr;
        end
    end

    assign brk_hit = (vma == brk_addr) && brk_en;

    // Burst stepping only advances the in-section offset; the section
    // number in the top five bits stays put and the offset wraps.
    assign vma_next = {vma[22:18], vma[17:0] + 18'd1};

    assign busy  = (state != S_IDLE);
    assign fault = (state == S_FAULT);

    // Sequencer: grant in IDLE, start a word in START, wait for the memory
    // in WAIT, and park in FAULT until fault_clr. Pulse outputs default low
    // every cycle so each is high for exactly one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            vma         <= '0;
            vma_held    <= '0;
            count       <= '0;
            cur_fetch   <= 1'b0;
            prio_diag   <= 1'b1;
            mem_start   <= 1'b0;
            mem_write   <= 1'b0;
            grant_diag  <= 1'b0;
            ebox_done   <= 1'b0;
            diag_done   <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            mem_start <= 1'b0;
            ebox_done <= 1'b0;
            diag_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        state      <= S_START;
                        grant_diag <= pick_diag;
                        if (pick_diag) begin
                            vma       <= diag_addr;
                            count     <= diag_count;
                            mem_write <= diag_write;
                            cur_fetch <= 1'b0;
                        end else begin
                            vma       <= ebox_addr;
                            count     <= 3'd0;
                            mem_write <= ebox_write;
                            cur_fetch <= ebox_fetch;
                        end
                        // Only a contested grant hands priority to the loser.
                        if (contested) begin
                            prio_diag <= ~pick_diag;
                        end
                    end
                end

                S_START: begin
                    if (brk_hit) begin
                        vma_held    <= vma;
                        fault_cause <= 2'b10;
                        state       <= S_FAULT;
                    end else begin
                        mem_start <= 1'b1;
                        state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // A page failure overrides an acknowledge in the same cycle.
                    if (page_fail) begin
                        vma_held    <= vma;
                        fault_cause <= 2'b01;
                        state       <= S_FAULT;
                    end else if (mem_ack) begin
                        if (count == 3'd0) begin
                            ebox_done <= ~grant_diag;
                            diag_done <= grant_diag;
                            state     <= S_IDLE;
                        end else begin
                            count <= count - 3'd1;
                            vma   <= vma_next;
                            state <= S_START;
                        end
                    end
                end

                S_FAULT: begin
                    if (fault_clr) begin
                        fault_cause <= 2'b00;
                        count       <= 3'd0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vma_seq.sv
// ---------------------------------------------------------------------------
// tb_vma_seq -- self-checking bench for vma_seq
//
// A scoreboard holds, in order, every memory cycle the sequencer must start
// (address, type, owner) and every completion pulse it must give. Those
// entries come from transaction-level rules: a burst of n+1 words starting
// at section/offset steps the offset modulo 2^18. A single compare process
// checks every mem_start and done pulse against the scoreboard; the directed
// sequence adds hand-computed literal checks for reset, faults and arbitration.
// ---------------------------------------------------------------------------
module tb_vma_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ebox_req;
    logic [22:0] ebox_addr;
    logic        ebox_write;
    logic        ebox_fetch;
    logic        diag_req;
    logic [22:0] diag_addr;
    logic        diag_write;
    logic [2:0]  diag_count;
    logic        mem_ack;
    logic        page_fail;
    logic [22:0] brk_addr;
    logic        brk_rd;
    logic        brk_wr;
    logic        brk_fetch;
    logic        fault_clr;
    logic [22:0] vma;
    logic [22:0] vma_held;
    logic        mem_start;
    logic        mem_write;
    logic        grant_diag;
    logic        ebox_done;
    logic        diag_done;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    typedef struct packed {
        logic [22:0] addr;
        logic        write;
        logic        diag;
    } start_t;

    start_t expStart[$];
    logic   expDone[$];

    logic [22:0] t2Lit [3];

    vma_seq dut (
        .clk(clk), .rst_n(rst_n),
        .ebox_req(ebox_req), .ebox_addr(ebox_addr),
        .ebox_write(ebox_write), .ebox_fetch(ebox_fetch),
        .diag_req(diag_req), .diag_addr(diag_addr),
        .diag_write(diag_write), .diag_count(diag_count),
        .mem_ack(mem_ack), .page_fail(page_fail),
        .brk_addr(brk_addr), .brk_rd(brk_rd), .brk_wr(brk_wr),
        .brk_fetch(brk_fetch), .fault_clr(fault_clr),
        .vma(vma), .vma_held(vma_held), .mem_start(mem_start),
        .mem_write(mem_write), .grant_diag(grant_diag),
        .ebox_done(ebox_done), .diag_done(diag_done),
        .fault(fault), .fault_cause(fault_cause), .busy(busy)
    );

    // 10 ns clock; the bench drives and samples on the falling edge.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Address of word i of a burst: section is base div 2^18, offset
    // advances modulo 2^18.
    function automatic logic [22:0] wordAddr(input logic [22:0] base, input int i);
        int unsigned b;
        int unsigned section;
        int unsigned offset;
        b       = {9'd0, base};
        section = b / 262144;
        offset  = (b % 262144 + i) % 262144;
        return 23'(section * 262144 + offset);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Queue the cycles and the completion of one request.
    task automatic expectBurst(input logic [22:0] base, input int words,
                               input logic wr, input logic isDiag, input bit completes);
        for (int i = 0; i < words; i++) begin
            expStart.push_back('{addr: wordAddr(base, i), write: wr, diag: isDiag});
        end
        if (completes) expDone.push_back(isDiag);
    endtask

    // Compare process: every mem_start and every done pulse must match the
    // next scoreboard entry.
    always @(negedge clk) begin : compare
        start_t s;
        logic   d;
        if (checkEn) begin
            if (mem_start) begin
                if (expStart.size() == 0) begin
                    checkOutput("spurious mem_start", 32'(mem_start), 32'd0);
                end else begin
                    s = expStart.pop_front();
                    checkOutput("start vma", 32'(vma), 32'(s.addr));
                    checkOutput("start mem_write", 32'(mem_write), 32'(s.write));
                    checkOutput("start owner", 32'(grant_diag), 32'(s.diag));
                    checkOutput("start busy", 32'(busy), 32'd1);
                end
            end
            if (ebox_done || diag_done) begin
                if (expDone.size() == 0) begin
                    checkOutput("spurious done", 32'({ebox_done, diag_done}), 32'd0);
                end else begin
                    d = expDone.pop_front();
                    checkOutput("done ebox", 32'(ebox_done), 32'(!d));
                    checkOutput("done diag", 32'(diag_done), 32'(d));
                    checkOutput("busy at done", 32'(busy), 32'd0);
                end
            end
        end
    end

    // Present a request from one of the two requesters.
    task automatic applyStimulus(input bit isDiag, input logic [22:0] addr,
                                 input logic wr, input logic fetch, input logic [2:0] cnt);
        if (isDiag) begin
            diag_addr  = addr;
            diag_write = wr;
            diag_count = cnt;
            diag_req   = 1'b1;
        end else begin
            ebox_addr  = addr;
            ebox_write = wr;
            ebox_fetch = fetch;
            ebox_req   = 1'b1;
        end
    endtask

    // Wait (bounded) for a DUT output; an expired bound is a failed check.
    task automatic waitSig(input int sel, input int maxCyc, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < maxCyc && !seen; i++) begin
            @(negedge clk);
            case (sel)
                0:       seen = mem_start;
                1:       seen = fault;
                default: seen = 1'b0;
            endcase
        end
        checkOutput(name, 32'(seen), 32'd1);
    endtask

    // Memory answers lat cycles later; returns on the edge showing the outcome.
    task automatic respond(input int lat, input logic pf);
        repeat (lat) @(negedge clk);
        mem_ack   = 1'b1;
        page_fail = pf;
        @(negedge clk);
        mem_ack   = 1'b0;
        page_fail = 1'b0;
    endtask

    task automatic clearFault();
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checkOutput("fault cleared", 32'(fault), 32'd0);
        checkOutput("idle after clear", 32'(busy), 32'd0);
        checkOutput("cause cleared", 32'(fault_cause), 32'd0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " vma"}, 32'(vma), 32'd0);
        checkOutput({tag, " vma_held"}, 32'(vma_held), 32'd0);
        checkOutput({tag, " mem_start"}, 32'(mem_start), 32'd0);
        checkOutput({tag, " mem_write"}, 32'(mem_write), 32'd0);
        checkOutput({tag, " grant_diag"}, 32'(grant_diag), 32'd0);
        checkOutput({tag, " ebox_done"}, 32'(ebox_done), 32'd0);
        checkOutput({tag, " diag_done"}, 32'(diag_done), 32'd0);
        checkOutput({tag, " fault"}, 32'(fault), 32'd0);
        checkOutput({tag, " fault_cause"}, 32'(fault_cause), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // Both requesters rise together; firstDiag says who must win.
    task automatic contestRound(input bit firstDiag, input logic [22:0] ea,
                                input logic [22:0] da);
        if (firstDiag) begin
            expectBurst(da, 1, 1'b0, 1'b1, 1'b1);
            expectBurst(ea, 1, 1'b0, 1'b0, 1'b1);
        end else begin
            expectBurst(ea, 1, 1'b0, 1'b0, 1'b1);
            expectBurst(da, 1, 1'b0, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, ea, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, da, 1'b0, 1'b0, 3'd0);
        waitSig(0, 10, "contest first start");
        checkOutput("contest first owner", 32'(grant_diag), 32'(firstDiag));
        respond(1, 1'b0);
        if (firstDiag) diag_req = 1'b0;
        else           ebox_req = 1'b0;
        @(negedge clk);
        checkOutput("no grant in done cycle", 32'(busy), 32'd0);
        waitSig(0, 10, "contest second start");
        checkOutput("contest second owner", 32'(grant_diag), 32'(!firstDiag));
        respond(1, 1'b0);
        ebox_req = 1'b0;
        diag_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        t2Lit[0] = 23'o3777776;
        t2Lit[1] = 23'o3777777;
        t2Lit[2] = 23'o3000000;

        rst_n = 1'b0;
        ebox_req = 1'b0; ebox_addr = '0; ebox_write = 1'b0; ebox_fetch = 1'b0;
        diag_req = 1'b0; diag_addr = '0; diag_write = 1'b0; diag_count = '0;
        mem_ack = 1'b0; page_fail = 1'b0;
        brk_addr = '0; brk_rd = 1'b0; brk_wr = 1'b0; brk_fetch = 1'b0;
        fault_clr = 1'b0;

        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        checkEn = 1'b1;
        repeat (2) @(negedge clk);

        // EBOX data read, memory answers three cycles after mem_start.
        $display("[TB] EBOX single read");
        expectBurst(23'o1234567, 1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 23'o1234567, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        checkOutput("t1 busy after grant", 32'(busy), 32'd1);
        checkOutput("t1 no start in grant cycle", 32'(mem_start), 32'd0);
        @(negedge clk);
        checkOutput("t1 start one cycle after grant", 32'(mem_start), 32'd1);
        @(negedge clk);
        checkOutput("t1 start lasts one cycle", 32'(mem_start), 32'd0);
        repeat (2) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("t1 ebox_done", 32'(ebox_done), 32'd1);
        checkOutput("t1 vma", 32'(vma), 32'(23'o1234567));
        ebox_req = 1'b0;
        @(negedge clk);
        checkOutput("t1 done lasts one cycle", 32'(ebox_done), 32'd0);
        repeat (2) @(negedge clk);

        // Diagnostic 3-word burst across the offset wrap.
        $display("[TB] diag burst with wrap");
        expectBurst(23'o3777776, 3, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 23'o3777776, 1'b1, 1'b0, 3'd2);
        for (int w = 0; w < 3; w++) begin
            waitSig(0, 10, "t2 start");
            checkOutput("t2 vma literal", 32'(vma), 32'(t2Lit[w]));
            respond(1, 1'b0);
        end
        checkOutput("t2 diag_done", 32'(diag_done), 32'd1);
        diag_req = 1'b0;
        repeat (2) @(negedge clk);

        // Arbitration: first contention to diag, next one to EBOX.
        $display("[TB] arbitration");
        contestRound(1'b1, 23'o0100000, 23'o0200000);
        contestRound(1'b0, 23'o0100001, 23'o0200001);

        // Page fail together with ack on word 2 of a burst.
        $display("[TB] page fail mid burst");
        expectBurst(23'o0500100, 2, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 23'o0500100, 1'b0, 1'b0, 3'd2);
        waitSig(0, 10, "t4 word1 start");
        respond(1, 1'b0);
        waitSig(0, 10, "t4 word2 start");
        respond(1, 1'b1);
        checkOutput("t4 fault", 32'(fault), 32'd1);
        checkOutput("t4 cause", 32'(fault_cause), 32'd1);
        checkOutput("t4 vma_held", 32'(vma_held), 32'(23'o0500101));
        checkOutput("t4 no diag_done", 32'(diag_done), 32'd0);
        diag_req = 1'b0;
        respond(0, 1'b0);
        @(negedge clk);
        checkOutput("t4 ack ignored in fault", 32'(fault), 32'd1);
        clearFault();
        repeat (2) @(negedge clk);

        // Address break on an EBOX write, then the same write without it.
        $display("[TB] address break");
        brk_addr = 23'o1777777;
        brk_wr   = 1'b1;
        applyStimulus(1'b0, 23'o1777777, 1'b1, 1'b0, 3'd0);
        waitSig(1, 10, "t5 break fault");
        checkOutput("t5 cause", 32'(fault_cause), 32'd2);
        checkOutput("t5 vma_held", 32'(vma_held), 32'(23'o1777777));
        ebox_req = 1'b0;
        clearFault();
        brk_wr = 1'b0;
        brk_rd = 1'b1;
        expectBurst(23'o1777777, 1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 23'o1777777, 1'b1, 1'b0, 3'd0);
        waitSig(0, 10, "t5 write start");
        respond(0, 1'b0);
        checkOutput("t5 write completes", 32'(ebox_done), 32'd1);
        ebox_req = 1'b0;
        repeat (2) @(negedge clk);
        brk_rd    = 1'b0;
        brk_wr    = 1'b1;
        brk_fetch = 1'b1;
        applyStimulus(1'b0, 23'o1777777, 1'b0, 1'b1, 3'd0);
        waitSig(1, 10, "t5 fetch break fault");
        checkOutput("t5 fetch cause", 32'(fault_cause), 32'd2);
        ebox_req = 1'b0;
        clearFault();
        brk_wr    = 1'b0;
        brk_fetch = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in WAIT of a 4-word burst won in contention.
        $display("[TB] reset mid burst");
        expectBurst(23'o2000010, 2, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 23'o0300000, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 23'o2000010, 1'b1, 1'b0, 3'd3);
        waitSig(0, 10, "t6 word1 start");
        checkOutput("t6 owner", 32'(grant_diag), 32'd1);
        respond(1, 1'b0);
        waitSig(0, 10, "t6 word2 start");
        rst_n    = 1'b0;
        ebox_req = 1'b0;
        diag_req = 1'b0;
        @(negedge clk);
        checkResetOutputs("t6 reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        contestRound(1'b1, 23'o0300001, 23'o0400001);

        checkOutput("start queue drained", 32'(expStart.size()), 32'd0);
        checkOutput("done queue drained", 32'(expDone.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vma_seq.md
VMA_SEQ -- requirements
Module: vma_seq

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 ebox_req  in  1  EBOX microcode requests a one-word memory cycle; held until ebox_done.
REQ-004 ebox_addr  in  23  EBOX address, bits [13:35].
REQ-005 ebox_write, ebox_fetch  in  1 each  EBOX cycle type: write / instruction fetch (both 0 = data read).
REQ-006 diag_req  in  1  diagnostic/front-end requests a burst; held until diag_done.
REQ-007 diag_addr  in  23  diagnostic start address [13:35].
REQ-008 diag_write  in  1  diagnostic cycle is a write.
REQ-009 diag_count  in  3  burst length minus one (0 = 1 word, 7 = 8 words).
REQ-010 mem_ack  in  1  memory cycle complete.
REQ-011 page_fail  in  1  current cycle page-failed.
REQ-012 brk_addr  in  23  address-break compare value [13:35].
REQ-013 brk_rd, brk_wr, brk_fetch  in  1 each  address-break enables per cycle type.
REQ-014 fault_clr  in  1  clears FAULT state.
REQ-015 vma  out  23  current virtual memory address [13:35].
REQ-016 vma_held  out  23  VMA captured at a fault.
REQ-017 mem_start  out  1  one-cycle pulse starting a memory cycle at vma.
REQ-018 mem_write  out  1  type of the active cycle; valid while busy.
REQ-019 grant_diag  out  1  1 = diagnostic owns the VMA, 0 = EBOX; valid while busy.
REQ-020 ebox_done, diag_done  out  1 each  one-cycle completion pulses.
REQ-021 fault  out  1  sequencer in FAULT state.
REQ-022 fault_cause  out  2  00 none, 01 page fail, 10 address break.
REQ-023 busy  out  1  state is not IDLE.

Function
REQ-024 States SHALL be IDLE, START, WAIT, FAULT.
REQ-025 IDLE, one request pending: grant it, load vma from that requester's address, load burst counter (diag_count, or 0 for EBOX), latch cycle type, go to START.
REQ-026 IDLE, both pending: SHALL grant the requester that did not win the previous arbitration; the first contention after reset goes to diag; the priority bit toggles only on contested grants.
REQ-027 START: if address break hits (REQ-032), go to FAULT with cause 10, no mem_start; else pulse mem_start for exactly this cycle, go to WAIT.
REQ-028 WAIT, page_fail=1: vma_held <= vma, cause 01, go to FAULT; page_fail SHALL win over a simultaneous mem_ack.
REQ-029 WAIT, mem_ack=1, counter=0: pulse the owner's done, go to IDLE; a new grant SHALL NOT occur before the next cycle.
REQ-030 WAIT, mem_ack=1, counter>0: decrement counter, increment vma, go to START.
REQ-031 Increment SHALL apply to vma[18:35] only, wrapping 777777 -> 000000; section bits [13:17] SHALL be unchanged.
REQ-032 Break hit: vma == brk_addr (all 23 bits) AND the enable for the latched type is 1 (fetch -> brk_fetch, write -> brk_wr, else brk_rd); on a break, vma_held <= vma.
REQ-033 FAULT: fault=1, no done pulse, requests ignored; fault_clr=1 -> IDLE, cause 00, burst abandoned; the owning requester SHALL drop and reissue its request.
REQ-034 mem_ack or page_fail outside WAIT SHALL be ignored.
REQ-035 Request inputs SHALL be sampled only in IDLE; address/type changes while busy have no effect.

Reset
REQ-036 rst_n=0 at a clock edge: state IDLE; vma, vma_held 0; counter 0; priority bit selects diag; all pulse outputs, fault, busy 0; cause 00; mem_write, grant_diag 0.
REQ-037 Reset SHALL take effect from any state, including mid-burst and FAULT, with no done pulse.

Verification
REQ-038 EBOX read of 0o0001234567 (brk off): mem_start one cycle after grant; ack after 3 cycles -> ebox_done 1 cycle; vma = 0o0001234567; busy 0 next cycle.
REQ-039 Diag burst at section 3, offset 777776, count 2: vma sequence 3/777776, 3/777777, 3/000000; three mem_starts; diag_done after third ack.
REQ-040 ebox_req and diag_req rise together twice in succession: diag granted first, EBOX second.
REQ-041 page_fail and mem_ack same cycle on word 2 of a diag burst: fault=1, cause 01, vma_held = word-2 address, no diag_done; fault_clr -> IDLE.
REQ-042 brk_addr = ebox_addr, brk_wr=1, EBOX write: no mem_start, cause 10, vma_held = brk_addr; same with brk_wr=0 completes normally.
REQ-043 rst_n=0 during WAIT of a 4-word burst: next cycle all outputs at reset values; no done pulse.
